// File: rtl/echo_path_emulator.sv
// Echo path emulator: near + gain * far delayed by D samples, for driving an echo canceller.
// The echo buffer is zero-flushed after reset and after every configuration change.
module echo_path_emulator #(
  parameter int DATA_WIDTH    = 16,
  parameter int MAX_DELAY     = 256,
  parameter int DEFAULT_DELAY = 16,
  parameter int DEFAULT_GAIN  = 16384
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_valid,
  input  logic signed [DATA_WIDTH-1:0]  near_signal,
  input  logic signed [DATA_WIDTH-1:0]  far_signal,
  input  logic                          cfg_valid,
  input  logic [$clog2(MAX_DELAY)-1:0]  cfg_delay,
  input  logic signed [15:0]            cfg_gain,
  output logic                          cfg_ready,
  output logic signed [DATA_WIDTH-1:0]  input_signal,
  output logic signed [DATA_WIDTH-1:0]  echo_signal,
  output logic                          out_valid
);

  localparam int AW = $clog2(MAX_DELAY);
  localparam int PW = DATA_WIDTH + 16;

  typedef enum logic {FLUSH = 1'b0, RUN = 1'b1} state_t;

  state_t                        state;
  logic [AW-1:0]                 flush_cnt;
  logic [AW-1:0]                 wr_ptr;
  logic [AW-1:0]                 delay;
  logic [AW-1:0]                 rd_addr;
  logic signed [15:0]            gain;

  logic signed [DATA_WIDTH-1:0]  mem [MAX_DELAY];
  logic                          mem_we;
  logic [AW-1:0]                 mem_waddr;
  logic signed [DATA_WIDTH-1:0]  mem_wdata;

  logic                          accept_p0;
  logic signed [DATA_WIDTH-1:0]  delayed_p0;
  logic signed [PW-1:0]          prod_p0;
  logic signed [PW-1:0]          scaled_p0;
  logic signed [DATA_WIDTH-1:0]  echo_p0;
  logic signed [DATA_WIDTH:0]    sum_p0;

  function automatic logic signed [DATA_WIDTH-1:0] sat_scaled(input logic signed [PW-1:0] v);
    logic [PW-DATA_WIDTH:0] top;
    top = v[PW-1:DATA_WIDTH-1];
    if ((&top) || (~|top)) return v[DATA_WIDTH-1:0];
    else if (v[PW-1])      return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else                   return {1'b0, {(DATA_WIDTH-1){1'b1}}};
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] sat_sum(input logic signed [DATA_WIDTH:0] v);
    if (v[DATA_WIDTH] == v[DATA_WIDTH-1]) return v[DATA_WIDTH-1:0];
    else if (v[DATA_WIDTH])               return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else                                  return {1'b0, {(DATA_WIDTH-1){1'b1}}};
  endfunction

  // Stage p0: buffer read, gain multiply, shift and saturate, all within the accept cycle
  assign accept_p0 = sample_valid && (state == RUN);
  assign rd_addr   = wr_ptr - delay;

  always_comb begin
    delayed_p0 = mem[rd_addr];
    if (delay == '0) delayed_p0 = far_signal;
  end

  assign prod_p0   = PW'(gain) * PW'(delayed_p0);
  assign scaled_p0 = prod_p0 >>> 15;
  assign echo_p0   = sat_scaled(scaled_p0);
  assign sum_p0    = {near_signal[DATA_WIDTH-1], near_signal} + {echo_p0[DATA_WIDTH-1], echo_p0};

  // Single write port shared between the zero flush and incoming far samples
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_ptr;
    mem_wdata = far_signal;
    if (state == FLUSH) begin
      mem_we    = 1'b1;
      mem_waddr = flush_cnt;
      mem_wdata = '0;
    end else if (sample_valid) begin
      mem_we    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FLUSH;
      flush_cnt <= '0;
      wr_ptr    <= '0;
      delay     <= AW'(DEFAULT_DELAY);
      gain      <= 16'(DEFAULT_GAIN);
      cfg_ready <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= accept_p0;
      case (state)
        FLUSH: begin
          flush_cnt <= flush_cnt + 1'b1;
          if (flush_cnt == AW'(MAX_DELAY - 1)) begin
            state     <= RUN;
            cfg_ready <= 1'b1;
          end
        end
        RUN: begin
          if (sample_valid) wr_ptr <= wr_ptr + 1'b1;
          // A sample arriving with the request still used the old settings above
          if (cfg_valid) begin
            delay     <= cfg_delay;
            gain      <= cfg_gain;
            wr_ptr    <= '0;
            flush_cnt <= '0;
            state     <= FLUSH;
            cfg_ready <= 1'b0;
          end
        end
        default: state <= FLUSH;
      endcase
    end
  end

  // Stage p1: registered outputs, held between strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      input_signal <= '0;
      echo_signal  <= '0;
    end else if (accept_p0) begin
      input_signal <= sat_sum(sum_p0);
      echo_signal  <= far_signal;
    end
  end

endmodule

// File: tb/tb_echo_path_emulator.sv
// Directed bench for echo_path_emulator: flush timing, delay/gain paths, saturation, config and reset.
module tb_echo_path_emulator;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               sample_valid = 1'b0;
  logic signed [15:0] near_signal = '0;
  logic signed [15:0] far_signal = '0;
  logic               cfg_valid = 1'b0;
  logic [7:0]         cfg_delay = '0;
  logic signed [15:0] cfg_gain = '0;
  logic               cfg_ready;
  logic signed [15:0] input_signal;
  logic signed [15:0] echo_signal;
  logic               out_valid;

  int checks = 0;
  int errors = 0;
  int far_hist [600];
  int exp_in;

  always #5 clk = ~clk;

  echo_path_emulator dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .near_signal  (near_signal),
    .far_signal   (far_signal),
    .cfg_valid    (cfg_valid),
    .cfg_delay    (cfg_delay),
    .cfg_gain     (cfg_gain),
    .cfg_ready    (cfg_ready),
    .input_signal (input_signal),
    .echo_signal  (echo_signal),
    .out_valid    (out_valid)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int n, input int f);
    @(negedge clk);
    near_signal  = n[15:0];
    far_signal   = f[15:0];
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  // Drives samples throughout the flush; none may produce out_valid
  task automatic wait_ready(input string tag);
    int   cyc;
    logic seen;
    cyc  = -1;
    seen = 1'b0;
    near_signal  = 16'sd1234;
    far_signal   = 16'sd1234;
    sample_valid = 1'b1;
    for (int n = 1; n <= 1000; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
      if (cfg_ready) begin
        cyc = n;
        break;
      end
    end
    sample_valid = 1'b0;
    check({tag, "_len"}, cyc, 256);
    check({tag, "_ov"}, seen, 0);
  endtask

  initial begin
    for (int i = 0; i < 600; i++)
      far_hist[i] = (i == 0) ? -32768 : ((i * 37) % 200) - 100;

    // Reset state and initial flush
    repeat (3) @(posedge clk);
    #1;
    check("rst_in", input_signal, 0);
    check("rst_echo", echo_signal, 0);
    check("rst_ov", out_valid, 0);
    check("rst_rdy", cfg_ready, 0);
    rst = 1'b0;
    wait_ready("flush0");

    // Default delay 16, gain 0.5: impulse response
    for (int i = 0; i < 41; i++) begin
      send(0, (i == 0) ? 16384 : 0);
      check($sformatf("imp_in%0d", i), input_signal, (i == 16) ? 8192 : 0);
      check($sformatf("imp_echo%0d", i), echo_signal, (i == 0) ? 16384 : 0);
      if (i == 16) begin
        check("imp_ov", out_valid, 1);
        @(posedge clk);
        #1;
        check("hold_ov", out_valid, 0);
        check("hold_in", input_signal, 8192);
      end
    end

    // -3 * 0.5 = -1.5 floors to -2
    send(0, -3);
    for (int i = 0; i < 15; i++) send(0, 0);
    send(100, 0);
    check("round_in", input_signal, 98);

    // Bypass delay 0, gain 32767
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_delay = 8'd0;
    cfg_gain  = 16'sd32767;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    check("cfg1_rdy", cfg_ready, 0);
    wait_ready("flush1");
    send(20000, 20000);
    check("byp_pos_in", input_signal, 32767);
    check("byp_pos_echo", echo_signal, 20000);
    send(-20000, -20000);
    check("byp_neg_in", input_signal, -32768);
    check("byp_neg_echo", echo_signal, -20000);
    send(300, 200);
    check("byp_small_in", input_signal, 499);

    // Delay 255, gain -1.0: negation, product saturation, pointer wrap
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_delay = 8'd255;
    cfg_gain  = 16'sh8000;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    wait_ready("flush2");
    for (int i = 0; i < 600; i++) begin
      send(0, far_hist[i]);
      if (i < 255)                             exp_in = 0;
      else if (far_hist[i - 255] == -32768)    exp_in = 32767;
      else                                     exp_in = -far_hist[i - 255];
      check($sformatf("wrap_in%0d", i), input_signal, exp_in);
      check($sformatf("wrap_echo%0d", i), echo_signal, far_hist[i]);
    end

    // Config and sample together: sample uses old delay/gain
    @(negedge clk);
    cfg_valid    = 1'b1;
    cfg_delay    = 8'd4;
    cfg_gain     = 16'sd16384;
    near_signal  = 16'sd10;
    far_signal   = 16'sd1000;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    cfg_valid    = 1'b0;
    sample_valid = 1'b0;
    check("both_ov", out_valid, 1);
    check("both_in", input_signal, 10 - far_hist[345]);
    check("both_echo", echo_signal, 1000);
    check("both_rdy", cfg_ready, 0);
    wait_ready("flush3");
    for (int i = 0; i < 6; i++) begin
      send(0, 2000);
      check($sformatf("refill_in%0d", i), input_signal, (i >= 4) ? 1000 : 0);
    end

    // Reset in RUN with a sample present
    @(negedge clk);
    rst          = 1'b1;
    near_signal  = 16'sd5000;
    far_signal   = 16'sd5000;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    check("mrst_in", input_signal, 0);
    check("mrst_echo", echo_signal, 0);
    check("mrst_ov", out_valid, 0);
    check("mrst_rdy", cfg_ready, 0);
    rst = 1'b0;
    wait_ready("flush4");
    for (int i = 0; i < 17; i++) begin
      send(0, (i == 0) ? 1000 : 0);
      check($sformatf("dflt_in%0d", i), input_signal, (i == 16) ? 500 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/echo_path_emulator.md
ECHO_PATH_EMULATOR -- requirements
Module: echo_path_emulator

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the sample width (signed two's complement).
REQ-002 Parameter MAX_DELAY, default 256 (power of two), SHALL set the echo buffer depth in samples.
REQ-003 Parameter DEFAULT_DELAY, default 16, SHALL set the echo delay in effect after reset.
REQ-004 Parameter DEFAULT_GAIN, default 16384 (0.5 in Q1.15), SHALL set the echo gain in effect after reset.
REQ-005 clk  input  1  the only clock; all logic SHALL be clocked on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 sample_valid  input  1  one-cycle strobe qualifying near_signal and far_signal.
REQ-008 near_signal  input  DATA_WIDTH signed  desired (near-end) sample.
REQ-009 far_signal  input  DATA_WIDTH signed  far-end sample that produces the echo.
REQ-010 cfg_valid  input  1  configuration request.
REQ-011 cfg_delay  input  log2(MAX_DELAY)  requested echo delay in samples.
REQ-012 cfg_gain  input  16 signed  requested echo gain, Q1.15.
REQ-013 cfg_ready  output  1  high when a configuration is accepted this cycle.
REQ-014 input_signal  output  DATA_WIDTH signed  near + echo, for the canceller's input_signal.
REQ-015 echo_signal  output  DATA_WIDTH signed  undelayed far reference, for the canceller's echo_signal.
REQ-016 out_valid  output  1  one-cycle strobe qualifying input_signal and echo_signal.

Function
REQ-017 FSM SHALL have two states, FLUSH and RUN; cfg_ready SHALL equal (state==RUN).
REQ-018 In FLUSH the block SHALL write zero to one buffer entry per cycle, address 0..MAX_DELAY-1 via a flush counter, then enter RUN the cycle after writing entry MAX_DELAY-1 (exactly MAX_DELAY cycles in FLUSH).
REQ-019 In FLUSH, sample_valid SHALL be ignored (sample dropped, out_valid low, write pointer unchanged by samples).
REQ-020 In RUN, cfg_valid high SHALL latch cfg_delay and cfg_gain, reset the write pointer to 0, and enter FLUSH next cycle.
REQ-021 If cfg_valid and sample_valid are high in the same RUN cycle, the sample SHALL be processed with the old delay/gain and the configuration SHALL still be accepted.
REQ-022 In RUN, on sample_valid, far_signal SHALL be written at wr_ptr and wr_ptr SHALL increment modulo MAX_DELAY (wrap MAX_DELAY-1 -> 0).
REQ-023 Delayed sample SHALL be the far_signal received exactly D accepted samples earlier, D = current delay, read at (wr_ptr - D) mod MAX_DELAY; D=0 SHALL use the current far_signal (bypass, no buffer read).
REQ-024 echo = (gain * delayed) as a full 32-bit signed product, arithmetic-shifted right 15 (rounding toward negative infinity), saturated to DATA_WIDTH; the only overflow case (-32768 * -32768) SHALL give 32767.
REQ-025 input_signal SHALL be near_signal + echo computed at DATA_WIDTH+1 bits and saturated to [-32768, 32767].
REQ-026 echo_signal SHALL be the far_signal of the same accepted sample, unmodified.
REQ-027 Latency: out_valid, input_signal, echo_signal SHALL update on the clock edge following sample_valid (1 cycle); outputs SHALL hold between strobes.
REQ-028 Buffer SHALL be single-port-read/single-port-write per cycle, inferable as RAM.

Reset
REQ-029 When rst is high at a clock edge: state=FLUSH, flush counter=0, wr_ptr=0, delay=DEFAULT_DELAY, gain=DEFAULT_GAIN, input_signal=0, echo_signal=0, out_valid=0, cfg_ready=0.
REQ-030 rst mid-FLUSH or mid-RUN SHALL abort the current operation and restart the full flush; configuration SHALL revert to defaults.

Verification
REQ-031 Reset, wait 256 cycles -> cfg_ready rises on cycle 256 after rst release; sample_valid during flush -> no out_valid.
REQ-032 Defaults, far impulse 16384 at sample 0 then zeros, near=0 -> input_signal=8192 on output of sample 16, 0 elsewhere; echo_signal=16384 only on sample 0.
REQ-033 cfg_delay=0, cfg_gain=32767, far=near=20000 -> after flush, input_signal=32767 (saturated), echo_signal=20000.
REQ-034 cfg_delay=255, gain=-32768, far=-32768 at sample 0, near=0 -> sample 255 output input_signal=32767 (product saturation); wr_ptr wrap verified over 600 samples.
REQ-035 cfg_valid and sample_valid same RUN cycle -> that sample uses old delay/gain, FLUSH follows, buffer reads zero afterwards until refilled.
REQ-036 Assert rst mid-RUN -> all outputs 0 next cycle, defaults restored, full 256-cycle flush repeated.
